// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU decode/issue stage: opcodes, ALU OP codes,
// instruction field positions and the opcode-to-ALU-OP decode.
package alu_issue_stage_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 4;
    localparam int AW     = 2;

    localparam logic [3:0] OPC_ADD  = 4'b0000;
    localparam logic [3:0] OPC_SUB  = 4'b0001;
    localparam logic [3:0] OPC_AND  = 4'b0010;
    localparam logic [3:0] OPC_OR   = 4'b0011;
    localparam logic [3:0] OPC_SLT  = 4'b0100;
    localparam logic [3:0] OPC_NOR  = 4'b0101;
    localparam logic [3:0] OPC_NAND = 4'b0110;
    localparam logic [3:0] OPC_ADDI = 4'b0111;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_NOR  = 4'b1100,
        ALU_NAND = 4'b1101
    } alu_op_e;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RS_LSB  = 10;
    localparam int RT_LSB  = 8;
    localparam int RD_LSB  = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    // Illegal opcodes (MSB set) map to ALU_AND; callers gate issue separately.
    function automatic alu_op_e decode_op(input logic [3:0] opc);
        alu_op_e op;
        case (opc)
            OPC_ADD:  op = ALU_ADD;
            OPC_SUB:  op = ALU_SUB;
            OPC_AND:  op = ALU_AND;
            OPC_OR:   op = ALU_OR;
            OPC_SLT:  op = ALU_SLT;
            OPC_NOR:  op = ALU_NOR;
            OPC_NAND: op = ALU_NAND;
            OPC_ADDI: op = ALU_ADD;
            default:  op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// Register file for the issue stage: NREG x DATA_W flops, two read ports,
// one write port, r0 hardwired to zero, write-to-read bypass.
module issue_regfile
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [NREG-1:0][DATA_W-1:0] regs_q;
    logic [NREG-1:0][DATA_W-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata_a = regs_q[raddr_a];
        rdata_b = regs_q[raddr_b];
        if (we && (waddr == raddr_a)) rdata_a = wdata;
        if (we && (waddr == raddr_b)) rdata_b = wdata;
        if (raddr_a == '0) rdata_a = '0;
        if (raddr_b == '0) rdata_b = '0;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the 16-bit ALU: decodes the instruction, reads
// operands, checks the busy scoreboard and issues through a valid/ready register.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [3:0]        ex_op,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [AW-1:0]     ex_dst,
    output logic              ex_wen,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              illegal
);

    logic [3:0]        opc;
    logic [AW-1:0]     rs, rt, rd, dst;
    logic              is_illegal, is_addi;
    logic [DATA_W-1:0] imm_ext, rdata_a, rdata_b;
    logic              hazard, accept, issue;

    logic [NREG-1:0]   busy_q, busy_d;
    logic              ex_valid_q, ex_valid_d;
    logic [3:0]        ex_op_q, ex_op_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic [AW-1:0]     ex_dst_q, ex_dst_d;
    logic              ex_wen_q, ex_wen_d;
    logic              illegal_q, illegal_d;

    issue_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    always_comb begin
        opc        = in_instr[OPC_MSB:OPC_LSB];
        rs         = in_instr[RS_LSB +: AW];
        rt         = in_instr[RT_LSB +: AW];
        rd         = in_instr[RD_LSB +: AW];
        is_illegal = opc[3];
        is_addi    = (opc == OPC_ADDI);
        dst        = is_addi ? rt : rd;
        imm_ext    = {{(DATA_W-IMM_W){in_instr[IMM_MSB]}}, in_instr[IMM_MSB:IMM_LSB]};
    end

    // A busy register is not a hazard if this cycle's writeback clears it;
    // busy_q[0] is never set, so r0 sources never stall.
    always_comb begin
        hazard = 1'b0;
        if (!is_illegal) begin
            if (busy_q[rs] && !(wb_en && (wb_addr == rs))) hazard = 1'b1;
            if (!is_addi && busy_q[rt] && !(wb_en && (wb_addr == rt))) hazard = 1'b1;
            if (busy_q[dst] && !(wb_en && (wb_addr == dst))) hazard = 1'b1;
        end
        in_ready = !rst && !hazard && (!ex_valid_q || ex_ready);
        accept   = in_valid && in_ready;
        issue    = accept && !is_illegal;
    end

    always_comb begin
        busy_d = busy_q;
        if (wb_en) busy_d[wb_addr] = 1'b0;
        if (issue && (dst != '0)) busy_d[dst] = 1'b1;
        busy_d[0] = 1'b0;

        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_dst_d   = ex_dst_q;
        ex_wen_d   = ex_wen_q;
        if (issue) begin
            ex_valid_d = 1'b1;
            ex_op_d    = decode_op(opc);
            ex_a_d     = rdata_a;
            ex_b_d     = is_addi ? imm_ext : rdata_b;
            ex_dst_d   = dst;
            ex_wen_d   = (dst != '0);
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end

        illegal_d = accept && is_illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_dst_q   <= '0;
            ex_wen_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_dst_q   <= ex_dst_d;
            ex_wen_q   <= ex_wen_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_op    = ex_op_q;
    assign ex_a     = ex_a_q;
    assign ex_b     = ex_b_q;
    assign ex_dst   = ex_dst_q;
    assign ex_wen   = ex_wen_q;
    assign illegal  = illegal_q;

endmodule
